encoder_16to4_irq: RTL and testbench
====================================

// Module: encoder_16to4_irq
// PURPOSE
//  Sequential 16-to-4 priority encoder; inverse end of the 4-to-16 decoder path.
//  Captures rising edges on 16 one-bit request lines d0..d15 into a sticky pending set.
//  Presents one encoded index i3..i0 with valid; holds it until the consumer acks.
//  On ack, clears the serviced request. Feeds the decoder or a MyHDL co-sim consumer.
// PARAMETERS
//  N_IN    16  request lines; fixed at 16 by the scalar port list.
//  CODE_W  4   code width, log2(N_IN).
// PORTS
//  clk      in   1  single clock, rising edge.
//  rst_n    in   1  asynchronous, active-low reset.
//  d0..d15  in   1  request lines, each edge-detected independently.
//  ack      in   1  consumer accepts the presented code.
//  i0..i3   out  1  encoded index; i0 = LSB.
//  valid    out  1  i3..i0 holds a granted request.
//  missed   out  1  one-cycle pulse: rising edge seen on an already-pending line.
// BEHAVIOUR
//  Reset (async, rst_n=0): pending=0, d_prev=0, i3..i0=0, valid=0, missed=0, state=IDLE, rr_ptr=0.
//  Edge detect: rise[k] = d[k] & ~d_prev[k]; d_prev <= d every clock.
//  Pending set at the edge where rise is sampled; a level held high is captured once.
//  FSM states: IDLE, GRANT.
//   IDLE:  pending!=0 at an edge -> load code of winner, valid<=1, go GRANT.
//   IDLE:  pending==0 -> stay; valid=0.
//   GRANT: outputs frozen while ack=0; no re-arbitration.
//   GRANT: ack=1 -> pending[code]<=0, valid<=0, go IDLE.
//  Latency: d[k] first sampled high at edge E -> valid=1 after edge E+1.
//  Ack at edge M -> next valid no earlier than after edge M+1; one bubble cycle between grants.
//  Priority (fixed): highest index wins (d15 > ... > d0).
//  Ack while valid=0: ignored.
//  Same-cycle events:
//   rise[k] together with clear of pending[k]: set wins; k stays pending, no missed pulse.
//   rise[k] while pending[k]=1, not being cleared: missed=1 for exactly one cycle; pending unchanged.
//  Several rises in one cycle: all captured.
//  All 16 pending: serviced one per grant; no loss; order per priority rule.
//  Reset mid-GRANT: outputs drop immediately; all pending requests discarded.
// CONFIGURATION
//  ROUND_ROBIN_EN defined:
//   rr_ptr (CODE_W bits) updated on each ack to granted code + 1, mod 16.
//   Winner = first pending index searching upward from rr_ptr, wrapping 15 -> 0.
//  ROUND_ROBIN_EN undefined:
//   Fixed priority as above; rr_ptr not instantiated.
// STRUCTURE
//  Package enc_pkg: N_IN, CODE_W, state_t enum {IDLE, GRANT}, function pick_fixed(pending).
//  Sub-module prio_pick: combinational winner select.
//   Inputs: pending[15:0], rr_ptr. Outputs: code[3:0], any.
//   Rotating mode under ROUND_ROBIN_EN.
//  Top: edge-detect regs, pending reg, FSM, output regs.
// TESTING
//  1. Reset low mid-run -> all outputs 0 immediately, asynchronously; pending cleared.
//  2. d5 rises at edge E -> after E+1: valid=1, code=0101. Ack at M -> valid=0 after M. No second grant while d5 stays high.
//  3. d2, d9, d15 rise in the same cycle, fixed priority -> grants 1111, 1001, 0010, one per ack, each separated by one idle cycle.
//  4. Same as 3 with ROUND_ROBIN_EN, rr_ptr=10 -> grants 1111, 0010, 1001.
//  5. d7 pending, toggled 0->1 again before ack -> missed pulses once. Re-rise on the ack cycle -> code 0111 granted again, no missed pulse.
//  6. All 16 rise together, ack held high -> 16 grants, every code appears exactly once, then valid stays 0.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared definitions for the 16-to-4 request encoder: sizes, FSM state type
// and the fixed-priority winner function (highest index wins).
package enc_pkg;

    localparam int N_IN   = 16;
    localparam int CODE_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Highest set bit of pending; returns 0 when nothing is pending.
    function automatic logic [CODE_W-1:0] pick_fixed(input logic [N_IN-1:0] pending);
        logic [CODE_W-1:0] code;
        code = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (pending[k]) begin
                code = CODE_W'(k);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational winner select over the pending set.
// Build option: ROUND_ROBIN_EN -- when defined, the search starts at rr_ptr
// and walks upward with wrap 15 -> 0; otherwise highest index wins.
module prio_pick
    import enc_pkg::*;
(
    input  logic [N_IN-1:0]   pending,
`ifdef ROUND_ROBIN_EN
    input  logic [CODE_W-1:0] rr_ptr,
`endif
    output logic [CODE_W-1:0] code,
    output logic              any
);

    assign any = |pending;

`ifdef ROUND_ROBIN_EN
    // First pending index at or above rr_ptr, wrapping through 15 -> 0.
    always_comb begin
        logic              found;
        logic [CODE_W-1:0] idx;
        code  = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < N_IN; off++) begin
            idx = rr_ptr + CODE_W'(off);
            if (!found && pending[idx]) begin
                code  = idx;
                found = 1'b1;
            end
        end
    end
`else
    // Fixed priority: highest pending index.
    always_comb begin
        code = pick_fixed(pending);
    end
`endif

endmodule

// File: rtl/encoder_16to4_irq.sv
// Sequential 16-to-4 priority encoder with sticky, edge-captured requests.
// Rising edges on d0..d15 set pending bits; one winner is presented on
// i3..i0 with valid and held until ack, which clears that pending bit.
// Build option: ROUND_ROBIN_EN -- rotating priority with rr_ptr advanced
// to granted code + 1 on every ack; default is fixed highest-index priority.
module encoder_16to4_irq
    import enc_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    input  logic d4,
    input  logic d5,
    input  logic d6,
    input  logic d7,
    input  logic d8,
    input  logic d9,
    input  logic d10,
    input  logic d11,
    input  logic d12,
    input  logic d13,
    input  logic d14,
    input  logic d15,
    input  logic ack,
    output logic i0,
    output logic i1,
    output logic i2,
    output logic i3,
    output logic valid,
    output logic missed
);

    logic [N_IN-1:0]   d_vec;
    logic [N_IN-1:0]   d_prev;
    logic [N_IN-1:0]   rise;
    logic [N_IN-1:0]   pending;
    logic [N_IN-1:0]   clr;
    logic [N_IN-1:0]   pending_nxt;
    logic              missed_nxt;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] win_code;
    logic              win_any;
    logic              do_ack;
    state_t            state;

    assign d_vec = {d15, d14, d13, d12, d11, d10, d9, d8,
                    d7,  d6,  d5,  d4,  d3,  d2,  d1, d0};

    assign rise = d_vec & ~d_prev;

    // Ack only counts while a code is actually presented.
    assign do_ack = (state == GRANT) && ack;

    // Clearing the serviced bit and capturing a new edge can coincide; the
    // capture is OR-ed in after the clear so the new request survives.
    always_comb begin
        clr         = '0;
        if (do_ack) begin
            clr[code_q] = 1'b1;
        end
        pending_nxt = (pending & ~clr) | rise;
        missed_nxt  = |(rise & pending & ~clr);
    end

`ifdef ROUND_ROBIN_EN
    logic [CODE_W-1:0] rr_ptr;

    prio_pick u_pick (
        .pending (pending),
        .rr_ptr  (rr_ptr),
        .code    (win_code),
        .any     (win_any)
    );

    // Rotating pointer moves just past the code that was serviced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (do_ack) begin
            rr_ptr <= code_q + CODE_W'(1);
        end
    end
`else
    prio_pick u_pick (
        .pending (pending),
        .code    (win_code),
        .any     (win_any)
    );
`endif

    // Edge-detect history, sticky pending set and the missed-edge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_prev  <= '0;
            pending <= '0;
            missed  <= 1'b0;
        end else begin
            d_prev  <= d_vec;
            pending <= pending_nxt;
            missed  <= missed_nxt;
        end
    end

    // Grant FSM: arbitrate only from IDLE, freeze the code while in GRANT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            code_q <= '0;
            valid  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (win_any) begin
                        code_q <= win_code;
                        valid  <= 1'b1;
                        state  <= GRANT;
                    end else begin
                        valid  <= 1'b0;
                    end
                end
                GRANT: begin
                    if (ack) begin
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign {i3, i2, i1, i0} = code_q;

endmodule

// File: tb/tb_encoder_16to4_irq.sv
// Bench for encoder_16to4_irq: directed request patterns, expected grant
// codes queued by the stimulus and checked by an independent monitor.
module tb_encoder_16to4_irq;

    logic        clk;
    logic        rst_n;
    logic [15:0] dv;
    logic        ack;
    logic        i0, i1, i2, i3;
    logic        valid;
    logic        missed;

    int n_checks;
    int n_fail;
    int missed_cnt;
    int exp_q[$];

    encoder_16to4_irq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .d0     (dv[0]),
        .d1     (dv[1]),
        .d2     (dv[2]),
        .d3     (dv[3]),
        .d4     (dv[4]),
        .d5     (dv[5]),
        .d6     (dv[6]),
        .d7     (dv[7]),
        .d8     (dv[8]),
        .d9     (dv[9]),
        .d10    (dv[10]),
        .d11    (dv[11]),
        .d12    (dv[12]),
        .d13    (dv[13]),
        .d14    (dv[14]),
        .d15    (dv[15]),
        .ack    (ack),
        .i0     (i0),
        .i1     (i1),
        .i2     (i2),
        .i3     (i3),
        .valid  (valid),
        .missed (missed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int code_now();
        return int'({i3, i2, i1, i0});
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: on every new grant pop the expected code; also check that a
    // presented code stays frozen and that missed never lasts two cycles.
    initial begin
        int prev_valid;
        int prev_code;
        int prev_missed;
        prev_valid  = 0;
        prev_code   = 0;
        prev_missed = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_valid  = 0;
                prev_missed = 0;
            end else begin
                if (valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_grant", code_now(), -1);
                    end else begin
                        chk("grant_code", code_now(), exp_q.pop_front());
                    end
                end else if (valid && prev_valid) begin
                    chk("code_frozen", code_now(), prev_code);
                end
                if (missed) begin
                    missed_cnt++;
                    if (prev_missed != 0) chk("missed_one_cycle", 2, 1);
                end
                prev_valid  = int'(valid);
                prev_code   = code_now();
                prev_missed = int'(missed);
            end
        end
    end

    // Wait (bounded) for a presented code, ack it for one cycle and confirm
    // the bubble cycle that follows.
    task automatic ack_grant();
        int t;
        t = 0;
        while (!valid && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("grant_wait", int'(valid), 1);
        ack = 1'b1;
        @(posedge clk);
        #1;
        chk("bubble_after_ack", int'(valid), 0);
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        while (!valid && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("valid_wait", int'(valid), 1);
    endtask

    initial begin
        int base;
        int t;
        n_checks   = 0;
        n_fail     = 0;
        missed_cnt = 0;
        rst_n      = 1'b0;
        dv         = '0;
        ack        = 1'b0;

        // Reset state.
        #2;
        chk("rst_valid", int'(valid), 0);
        chk("rst_code", code_now(), 0);
        chk("rst_missed", int'(missed), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single request d5: latency, ack, no regrant while held high.
        exp_q.push_back(5);
        dv[5] = 1'b1;
        @(posedge clk);
        #1;
        chk("d5_not_yet", int'(valid), 0);
        @(posedge clk);
        #1;
        chk("d5_valid", int'(valid), 1);
        chk("d5_code", code_now(), 5);
        ack_grant();
        repeat (6) @(negedge clk);
        chk("d5_no_regrant", int'(valid), 0);
        dv[5] = 1'b0;
        repeat (2) @(negedge clk);

        // d2, d9, d15 together: highest index first.
        exp_q.push_back(15);
        exp_q.push_back(9);
        exp_q.push_back(2);
        dv[2] = 1'b1; dv[9] = 1'b1; dv[15] = 1'b1;
        ack_grant();
        ack_grant();
        ack_grant();
        dv = '0;
        repeat (3) @(negedge clk);
        chk("three_done_valid", int'(valid), 0);

        // d7 re-rises while pending: exactly one missed pulse.
        exp_q.push_back(7);
        dv[7] = 1'b1;
        wait_valid();
        base = missed_cnt;
        @(negedge clk);
        dv[7] = 1'b0;
        @(negedge clk);
        dv[7] = 1'b1;
        repeat (3) @(negedge clk);
        chk("d7_missed_once", missed_cnt - base, 1);
        chk("d7_still_held", code_now(), 7);
        dv[7] = 1'b0;
        @(negedge clk);
        // Re-rise on the ack cycle: stays pending, granted again, no pulse.
        base = missed_cnt;
        exp_q.push_back(7);
        dv[7] = 1'b1;
        ack   = 1'b1;
        @(posedge clk);
        #1;
        chk("d7_ack_bubble", int'(valid), 0);
        @(negedge clk);
        ack = 1'b0;
        ack_grant();
        repeat (3) @(negedge clk);
        chk("d7_no_missed_on_ack", missed_cnt - base, 0);
        dv[7] = 1'b0;
        repeat (2) @(negedge clk);

        // All sixteen at once with ack held high.
        base = missed_cnt;
        for (int k = 15; k >= 0; k--) exp_q.push_back(k);
        dv  = 16'hFFFF;
        ack = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 80) begin
            @(negedge clk);
            t++;
        end
        chk("all16_drained", exp_q.size(), 0);
        repeat (4) @(negedge clk);
        chk("all16_idle", int'(valid), 0);
        chk("all16_no_missed", missed_cnt - base, 0);
        ack = 1'b0;
        dv  = '0;
        repeat (2) @(negedge clk);

        // Reset during GRANT: asynchronous drop, pending discarded.
        exp_q.push_back(4);
        dv[3] = 1'b1; dv[4] = 1'b1;
        wait_valid();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(valid), 0);
        chk("arst_code", code_now(), 0);
        chk("arst_missed", int'(missed), 0);
        dv = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("arst_pending_gone", int'(valid), 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
